// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared constants and helpers for the simpleCNN datapath. The window packing
// helper win_idx() is the single definition of the window layout; the
// conv/FC core uses the same function to unpack windows.
//   IMG_W/IMG_H : image size in pixels
//   K           : window edge
//   PW          : pixel width (unsigned)
//   XY_W        : width of window origin coordinates
//   state_t     : window generator FSM encoding
// ---------------------------------------------------------------------------
package cnn_pkg;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 5;
  localparam int PW    = 8;
  localparam int XY_W  = 5;
  localparam int WIN_W = K * K * PW;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(K);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    EMIT = 3'd2,
    LOAD = 3'd3,
    DONE = 3'd4
  } state_t;

  // Bit offset of window pixel (row i, col j) inside the packed window.
  function automatic int win_idx(input int i, input int j);
    return (i * K + j) * PW;
  endfunction

endpackage

// File: rtl/cnn_window_gen_if.sv
// ---------------------------------------------------------------------------
// cnn_window_gen_if
// Pixel-in / window-out handshake bundle of the window generator.
//   master : upstream/downstream side (drives FRAME_START, pixels, WIN_READY)
//   slave  : cnn_window_gen side (drives PIX_READY, window outputs, status)
// ---------------------------------------------------------------------------
interface cnn_window_gen_if;
  import cnn_pkg::*;

  logic             FRAME_START;
  logic             PIX_VALID;
  logic [PW-1:0]    PIX_DATA;
  logic             PIX_READY;
  logic             WIN_VALID;
  logic             WIN_READY;
  logic [XY_W-1:0]  WIN_X;
  logic [XY_W-1:0]  WIN_Y;
  logic [WIN_W-1:0] WIN_DATA;
  logic             FRAME_DONE;
  logic             BUSY;

  modport master (
    output FRAME_START, PIX_VALID, PIX_DATA, WIN_READY,
    input  PIX_READY, WIN_VALID, WIN_X, WIN_Y, WIN_DATA, FRAME_DONE, BUSY
  );

  modport slave (
    input  FRAME_START, PIX_VALID, PIX_DATA, WIN_READY,
    output PIX_READY, WIN_VALID, WIN_X, WIN_Y, WIN_DATA, FRAME_DONE, BUSY
  );

endinterface

// File: rtl/cnn_line_buffer.sv
// ---------------------------------------------------------------------------
// cnn_line_buffer
// K-row ring of IMG_W pixels. One pixel written per cycle; the full KxK
// window at (rd_top, rd_x) is read combinationally.
//   CLK     : clock, rising edge
//   wr_en   : write strobe
//   wr_row  : physical ring row to write
//   wr_col  : column to write
//   wr_data : pixel
//   rd_top  : physical ring row holding window row 0
//   rd_x    : window column origin
//   win     : packed window, pixel (i,j) at win_idx(i,j)
// ---------------------------------------------------------------------------
module cnn_line_buffer
  import cnn_pkg::*;
(
  input  logic             CLK,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic [PW-1:0]    wr_data,
  input  logic [ROW_W-1:0] rd_top,
  input  logic [XY_W-1:0]  rd_x,
  output logic [WIN_W-1:0] win
);

  // Storage has no reset: contents are only read after being written.
  logic [PW-1:0] mem [K][IMG_W];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_row][wr_col] <= wr_data;
  end

  // Window row i lives in ring row (top+i) mod K. Columns past the image
  // edge only occur for the unused look-ahead origin and read as zero.
  always_comb begin : rd_mux
    int r;
    int c;
    win = '0;
    r   = 0;
    c   = 0;
    for (int i = 0; i < K; i++) begin
      r = int'(rd_top) + i;
      if (r >= K) r = r - K;
      for (int j = 0; j < K; j++) begin
        c = int'(rd_x) + j;
        if (c < IMG_W) win[win_idx(i, j) +: PW] = mem[ROW_W'(r)][COL_W'(c)];
      end
    end
  end

endmodule

// File: rtl/cnn_window_gen.sv
// ---------------------------------------------------------------------------
// cnn_window_gen
// Buffers K rows of a raster 28x28 image and emits every KxK window with its
// (X,Y) origin, Y-major then X, over a valid/ready handshake.
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset
//   bus   : cnn_window_gen_if.slave
//           FRAME_START/PIX_VALID/PIX_DATA/WIN_READY in,
//           PIX_READY/WIN_VALID/WIN_X/WIN_Y/WIN_DATA/FRAME_DONE/BUSY out
// ---------------------------------------------------------------------------
module cnn_window_gen
  import cnn_pkg::*;
(
  input  logic            CLK,
  input  logic            nRST,
  cnn_window_gen_if.slave bus
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(K - 1);
  localparam logic [XY_W-1:0]  X_LAST   = XY_W'(IMG_W - K);
  localparam logic [XY_W-1:0]  Y_LAST   = XY_W'(IMG_H - K);

  state_t           state, state_nxt;
  logic [COL_W-1:0] cnt_col;
  logic [ROW_W-1:0] cnt_row;
  logic [ROW_W-1:0] top;

  logic             vld_p0;
  logic [XY_W-1:0]  win_x_p0;
  logic [XY_W-1:0]  win_y_p0;
  logic [WIN_W-1:0] win_data_p0;

  logic             pix_ready;
  logic             pix_xfer;
  logic             win_xfer;
  logic             row_end;
  logic             last_x;
  logic             last_y;
  logic             load_win;
  logic [XY_W-1:0]  rd_x;
  logic [ROW_W-1:0] wr_row;
  logic [WIN_W-1:0] lb_win;

  assign pix_ready = (state == FILL) || (state == LOAD);
  assign pix_xfer  = bus.PIX_VALID && pix_ready;
  assign win_xfer  = vld_p0 && bus.WIN_READY;
  assign row_end   = (cnt_col == COL_LAST);
  assign last_x    = (win_x_p0 == X_LAST);
  assign last_y    = (win_y_p0 == Y_LAST);

  // Origin of the window to load next: the held origin while the window
  // register is empty, otherwise one column on, so a transfer and the next
  // load share an edge.
  assign rd_x   = vld_p0 ? (win_x_p0 + XY_W'(1)) : win_x_p0;
  assign wr_row = (state == FILL) ? cnt_row : top;

  // Load while empty, or on a transfer that is not the last of the row.
  assign load_win = (state == EMIT) && (!vld_p0 || (win_xfer && !last_x));

  cnn_line_buffer u_lb (
    .CLK     (CLK),
    .wr_en   (pix_xfer),
    .wr_row  (wr_row),
    .wr_col  (cnt_col),
    .wr_data (bus.PIX_DATA),
    .rd_top  (top),
    .rd_x    (rd_x),
    .win     (lb_win)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.FRAME_START) state_nxt = FILL;
      FILL: if (pix_xfer && row_end && (cnt_row == ROW_LAST)) state_nxt = EMIT;
      EMIT: if (win_xfer && last_x) state_nxt = last_y ? DONE : LOAD;
      LOAD: if (pix_xfer && row_end) state_nxt = EMIT;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: counters, ring pointer and window output registers ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_col     <= '0;
      cnt_row     <= '0;
      top         <= '0;
      vld_p0      <= 1'b0;
      win_x_p0    <= '0;
      win_y_p0    <= '0;
      win_data_p0 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.FRAME_START) begin
            cnt_col  <= '0;
            cnt_row  <= '0;
            top      <= '0;
            vld_p0   <= 1'b0;
            win_x_p0 <= '0;
            win_y_p0 <= '0;
          end
        end
        FILL: begin
          if (pix_xfer) begin
            if (row_end) begin
              cnt_col <= '0;
              cnt_row <= (cnt_row == ROW_LAST) ? '0 : (cnt_row + ROW_W'(1));
            end else begin
              cnt_col <= cnt_col + COL_W'(1);
            end
          end
        end
        EMIT: begin
          if (load_win) begin
            win_data_p0 <= lb_win;
            win_x_p0    <= rd_x;
            vld_p0      <= 1'b1;
          end else if (win_xfer) begin
            vld_p0 <= 1'b0;
          end
        end
        LOAD: begin
          if (pix_xfer) begin
            if (row_end) begin
              // New row overwrote the oldest one: it becomes window row K-1.
              cnt_col  <= '0;
              top      <= (top == ROW_LAST) ? '0 : (top + ROW_W'(1));
              win_y_p0 <= win_y_p0 + XY_W'(1);
              win_x_p0 <= '0;
            end else begin
              cnt_col <= cnt_col + COL_W'(1);
            end
          end
        end
        default: vld_p0 <= 1'b0;
      endcase
    end
  end

  assign bus.PIX_READY  = pix_ready;
  assign bus.WIN_VALID  = vld_p0;
  assign bus.WIN_X      = win_x_p0;
  assign bus.WIN_Y      = win_y_p0;
  assign bus.WIN_DATA   = win_data_p0;
  assign bus.FRAME_DONE = (state == DONE);
  assign bus.BUSY       = (state != IDLE);

endmodule

// File: tb/tb_cnn_window_gen.sv
// ---------------------------------------------------------------------------
// tb_cnn_window_gen
// Directed bench for cnn_window_gen: ramp frame, backpressure, pixel gaps with
// a stray FRAME_START, reset mid-LOAD, and back-to-back frames.
// ---------------------------------------------------------------------------
module tb_cnn_window_gen;

  localparam int W       = 28;
  localparam int H       = 28;
  localparam int KW      = 5;
  localparam int NX      = W - KW + 1;
  localparam int NWIN    = NX * (H - KW + 1);
  localparam int NPIX    = W * H;
  localparam int CYC_MAX = 6000;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int   tests = 0;
  int   fails = 0;

  cnn_window_gen_if bus();

  cnn_window_gen dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] pix(input int off, input int r, input int c);
    int v;
    v = (r * W + c + off) & 255;
    return v[7:0];
  endfunction

  function automatic logic [199:0] exp_win(input int off, input int x, input int y);
    logic [199:0] w;
    w = '0;
    for (int i = 0; i < KW; i++)
      for (int j = 0; j < KW; j++)
        w[(i * KW + j) * 8 +: 8] = pix(off, y + i, x + j);
    return w;
  endfunction

  function automatic logic [255:0] all_outs();
    return 256'({bus.PIX_READY, bus.WIN_VALID, bus.WIN_X, bus.WIN_Y, bus.WIN_DATA,
                 bus.FRAME_DONE, bus.BUSY});
  endfunction

  function automatic logic [255:0] win_outs();
    return 256'({bus.WIN_VALID, bus.WIN_X, bus.WIN_Y, bus.WIN_DATA});
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame. stall_pct: % of cycles WIN_READY is low; gap_pct: % of cycles
  // PIX_VALID is withheld; off: image offset; extra_start: stray FRAME_START
  // during EMIT; abort_y >= 0: pulse nRST mid-LOAD once WIN_Y == abort_y.
  task automatic run_frame(input int stall_pct, input int gap_pct, input int off,
                           input bit extra_start, input int abort_y);
    int pidx, widx, cyc, e_fill, first_vld, pix_at_vld, overlap, ex, ey;
    bit finished, aborted, stalled, pend_pix, sent_extra, rdy, give;
    logic [255:0] held;
    pidx = 0; widx = 0; cyc = 0; e_fill = -100; first_vld = -1; pix_at_vld = -1;
    overlap = 0; ex = 0; ey = 0;
    finished = 0; aborted = 0; stalled = 0; pend_pix = 0; sent_extra = 0;
    rdy = 0; give = 0; held = '0;

    bus.FRAME_START = 1'b1;
    @(posedge CLK); #1;
    bus.FRAME_START = 1'b0;

    while (!finished && !aborted && cyc < CYC_MAX) begin
      if (stalled) check("hold_while_stalled", win_outs(), held);
      if (bus.FRAME_DONE) begin
        finished = 1;
        check("done_after_last_win", widx, NWIN);
        check("done_vld_low", bus.WIN_VALID, 1'b0);
      end else if (abort_y >= 0 && bus.PIX_READY && bus.WIN_Y == 5'(abort_y) &&
                   (pidx % W) == 14) begin
        aborted = 1;
        bus.PIX_VALID   = 1'b0;
        bus.WIN_READY   = 1'b0;
        bus.FRAME_START = 1'b0;
        nRST = 1'b0;
        #2;
        check("rst_async_outs", all_outs(), '0);
        @(posedge CLK); #1;
        check("rst_held_outs", all_outs(), '0);
        nRST = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(posedge CLK); #1;
          check("no_done_after_rst", {bus.FRAME_DONE, bus.BUSY}, 2'b00);
        end
      end else begin
        if (bus.WIN_VALID && first_vld < 0) begin
          first_vld  = cyc;
          pix_at_vld = pidx;
        end
        if (bus.WIN_VALID && bus.PIX_READY) overlap++;
        rdy = ($urandom_range(0, 99) >= stall_pct);
        bus.WIN_READY = rdy;
        if (bus.WIN_VALID && rdy) begin
          ex = widx % NX;
          ey = widx / NX;
          check("win", win_outs(), 256'({1'b1, 5'(ex), 5'(ey), exp_win(off, ex, ey)}));
          if (off == 0 && widx == 0) check("w00_byte24", bus.WIN_DATA[24*8 +: 8], 8'h74);
          if (off == 0 && widx == 0) check("w00_byte0", bus.WIN_DATA[7:0], 8'h00);
          if (off == 0 && ex == 0 && ey == 5) check("w05_row0_byte0", bus.WIN_DATA[7:0], 8'h8C);
          if (off == 0 && ex == 23 && ey == 23) check("w2323_byte0", bus.WIN_DATA[7:0], 8'h9B);
          widx++;
        end
        stalled = bus.WIN_VALID && !rdy;
        held    = win_outs();
        give = (pidx < NPIX) && ($urandom_range(0, 99) >= gap_pct);
        bus.PIX_VALID = give;
        bus.PIX_DATA  = pix(off, pidx / W, pidx % W);
        pend_pix = give && bus.PIX_READY;
        bus.FRAME_START = 1'b0;
        if (extra_start && !sent_extra && bus.WIN_VALID && widx == 100) begin
          bus.FRAME_START = 1'b1;
          sent_extra = 1;
        end
        @(posedge CLK);
        cyc++;
        if (pend_pix) begin
          pidx++;
          if (pidx == KW * W) e_fill = cyc;
        end
        #1;
      end
    end

    bus.PIX_VALID   = 1'b0;
    bus.FRAME_START = 1'b0;
    if (abort_y >= 0) begin
      check("abort_reached", aborted, 1'b1);
    end else begin
      check("frame_done_seen", finished, 1'b1);
      check("pix_total", pidx, NPIX);
      check("pix_ready_low_in_emit", overlap, 0);
      check("rows_before_first_vld", pix_at_vld, KW * W);
      check("first_vld_latency", first_vld - e_fill, 1);
      @(posedge CLK); #1;
      check("idle_after_done", {bus.FRAME_DONE, bus.BUSY, bus.WIN_VALID}, 3'b000);
    end
  endtask

  initial begin
    bus.FRAME_START = 1'b0;
    bus.PIX_VALID   = 1'b0;
    bus.PIX_DATA    = '0;
    bus.WIN_READY   = 1'b0;
    nRST            = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_outs", all_outs(), '0);
    nRST = 1'b1;
    bus.PIX_VALID = 1'b1;
    bus.WIN_READY = 1'b1;
    @(posedge CLK); #1;
    check("idle_ignores_pix", all_outs(), '0);
    bus.PIX_VALID = 1'b0;
    bus.WIN_READY = 1'b0;

    run_frame(0, 0, 0, 1'b0, -1);     // ramp, WIN_READY high
    run_frame(30, 0, 0, 1'b0, -1);    // window backpressure
    run_frame(0, 50, 0, 1'b1, -1);    // pixel gaps + stray FRAME_START
    run_frame(0, 0, 0, 1'b0, 10);     // nRST mid-LOAD
    run_frame(0, 0, 0, 1'b0, -1);     // fresh frame after reset
    run_frame(20, 20, 85, 1'b0, -1);  // back-to-back, different image

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
